// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial add sequencer.
package add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Purely combinational 4-bit adder slice shared by every nibble step.
import add_seq_pkg::*;

module nibble_adder (
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] full;

    // Widen by one bit so the carry falls out of the top.
    assign full = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    assign sum  = full[NIBBLE_W-1:0];
    assign cout = full[NIBBLE_W];

endmodule

// File: rtl/add_sequencer.sv
// Nibble-serial adder: accepts an operand pair, adds one nibble per cycle
// LSB first through a single nibble_adder, then holds the result until the
// consumer takes it. Optional subtract mode behind ADD_SEQUENCER_SUB_EN.
import add_seq_pkg::*;

module add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADD_SEQUENCER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    cnt;
    logic             c_q, cout_q, sub_q, fin;
    logic             sub_in;

    logic [NIBBLE_W-1:0] a_nib, b_nib, n_sum;
    logic                n_cout;

`ifdef ADD_SEQUENCER_SUB_EN
    assign sub_in = in_sub;
`else
    assign sub_in = 1'b0;
`endif

    // Current nibble operands; B is inverted in subtract mode.
    assign a_nib = a_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[int'(cnt)*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};

    nibble_adder u_add (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (c_q),
        .sum  (n_sum),
        .cout (n_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state. fin marks that the last nibble has been written, so DONE
    // is entered one cycle after it, giving NIB+1 cycles of latency.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = CALC;
            CALC:    if (fin)       state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: latch operands on accept, then one nibble per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            sub_q  <= 1'b0;
            fin    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q    <= in_a;
                    b_q    <= in_b;
                    sub_q  <= sub_in;
                    c_q    <= sub_in ? 1'b1 : in_cin;
                    cnt    <= '0;
                    fin    <= 1'b0;
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                end
                CALC: if (!fin) begin
                    sum_q[int'(cnt)*NIBBLE_W +: NIBBLE_W] <= n_sum;
                    c_q <= n_cout;
                    if (cnt == LAST) begin
                        fin    <= 1'b1;
                        cout_q <= n_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule
